// File: rtl/n0prime_pkg.sv
// n0prime_pkg: shared state type and default widths
// for the Hensel-lifting Montgomery n0' generator.
package n0prime_pkg;

  localparam int N0_W_DEFAULT  = 32;
  localparam int N0_NW_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } n0_state_e;

  // bit-index width; never below one bit
  function automatic int n0_iw(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/n0inv_step.sv
// n0inv_step: one combinational Hensel lifting step
// that clears bit i of t by adding the shifted modulus.
module n0inv_step
  import n0prime_pkg::*;
#(
  parameter int W  = N0_W_DEFAULT,
  parameter int IW = n0_iw(W)
) (
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  nw,
  input  logic [IW-1:0] i,
  output logic [W-1:0]  t_next,
  output logic [W-1:0]  y_next
);

  logic [W-1:0] nw_sh;

  assign nw_sh = nw << i;

  // set y[i] and fold nw<<i into t when t[i] is still 1
  always_comb begin
    t_next = t;
    y_next = y;
    if (t[i]) begin
      t_next    = t + nw_sh;
      y_next[i] = 1'b1;
    end
  end

endmodule

// File: rtl/n0prime_hensel.sv
// n0prime_hensel: n0' = -n^-1 mod 2^W, one bit per cycle.
// Optional result self-check: N0PRIME_SELFCHECK_EN.
module n0prime_hensel
  import n0prime_pkg::*;
#(
  parameter int NW = N0_NW_DEFAULT,
  parameter int W  = N0_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic          chk_fail
);

  localparam int IW = n0_iw(W);
  localparam logic [IW-1:0] I_ONE  = IW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(W - 1);

  n0_state_e     state;
  logic [W-1:0]  nw;
  logic [W-1:0]  t;
  logic [W-1:0]  y;
  logic [IW-1:0] i;
  logic          even_q;

  logic [W-1:0]  t_nx;
  logic [W-1:0]  y_nx;
  logic [W-1:0]  neg_y;

  // upper modulus bits are deliberately ignored
  logic unused_n_hi;
  generate
    if (NW > W) begin : g_hi
      assign unused_n_hi = ^n[NW-1:W];
    end else begin : g_no_hi
      assign unused_n_hi = 1'b0;
    end
  endgenerate

  n0inv_step #(
    .W  (W),
    .IW (IW)
  ) u_step (
    .t      (t),
    .y      (y),
    .nw     (nw),
    .i      (i),
    .t_next (t_nx),
    .y_next (y_nx)
  );

  assign neg_y = ~y + W'(1);

  // control FSM with registered handshake and result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      nw     <= '0;
      t      <= '0;
      y      <= '0;
      i      <= '0;
      even_q <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            nw     <= n[W-1:0];
            t      <= n[W-1:0];
            y      <= W'(1);
            i      <= I_ONE;
            busy   <= 1'b1;
            err    <= 1'b0;
            even_q <= ~n[0];
            state  <= n[0] ? CALC : FIN;
          end
        end
        CALC: begin
          t <= t_nx;
          y <= y_nx;
          i <= i + I_ONE;
          if (i == I_LAST) begin
            state <= FIN;
          end
        end
        FIN: begin
          result <= even_q ? '0 : neg_y;
          err    <= even_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef N0PRIME_SELFCHECK_EN
  logic [W-1:0] prod;

  assign prod = nw * neg_y;

  // flag a result whose product with n is not -1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_fail <= 1'b0;
    end else if (state == IDLE && start) begin
      chk_fail <= 1'b0;
    end else if (state == FIN && !even_q) begin
      chk_fail <= (prod != '1);
    end
  end
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_n0prime_hensel.sv
// tb_n0prime_hensel: scoreboard bench for the n0'
// generator at W=32/NW=1024 and W=16/NW=64.
module tb_n0prime_hensel;
  import n0prime_pkg::*;

  localparam int W   = 32;
  localparam int NW  = 1024;
  localparam int W2  = 16;
  localparam int NW2 = 64;
  localparam int TMO = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic [NW-1:0] n;
  logic          busy;
  logic          done;
  logic          err;
  logic [W-1:0]  result;
  logic          chk_fail;

  logic           start2;
  logic [NW2-1:0] n2;
  logic           busy2;
  logic           done2;
  logic           err2;
  logic [W2-1:0]  result2;
  logic           chk2;

  n0prime_hensel #(.NW(NW), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .chk_fail (chk_fail)
  );

  n0prime_hensel #(.NW(NW2), .W(W2)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .n        (n2),
    .busy     (busy2),
    .done     (done2),
    .err      (err2),
    .result   (result2),
    .chk_fail (chk2)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  // Newton iteration inverse, independent of bit-serial lifting
  function automatic logic [W-1:0] model_n0(input logic [W-1:0] nl);
    logic [W-1:0] x;
    if (!nl[0]) return '0;
    x = nl;
    for (int k = 0; k < 5; k++) x = x * (W'(2) - nl * x);
    return ~x + W'(1);
  endfunction

  function automatic logic [NW-1:0] rand_wide();
    logic [NW-1:0] v;
    for (int k = 0; k < NW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // push expectation, pulse start; returns at negedge after accept
  task automatic issue(input logic [NW-1:0] nv,
                       input logic [W-1:0] eres,
                       input logic eerr);
    exp_t e;
    e.res = eres;
    e.err = eerr;
    sb.push_back(e);
    @(negedge clk);
    n = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = rand_wide();
  endtask

  task automatic wait_done(output int cyc, output bit to);
    cyc = 0;
    to = 1'b0;
    while (done !== 1'b1) begin
      @(negedge clk);
      cyc++;
      if (cyc > TMO) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    n = '0;
    n2 = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, err, chk_fail, result} !== '0)
      $display("FAIL reset32 got b%b d%b e%b c%b r%h want 0",
               busy, done, err, chk_fail, result);
    else pass_cnt++;
    total_cnt++;
    if ({busy2, done2, err2, chk2, result2} !== '0)
      $display("FAIL reset16 got b%b d%b e%b c%b r%h want 0",
               busy2, done2, err2, chk2, result2);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_n1();
    int cyc;
    bit to;
    exp_t e;
    issue(NW'(1), 32'hFFFF_FFFF, 1'b0);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL n1_busy got %b want 1", busy);
    else pass_cnt++;
    wait_done(cyc, to);
    e = sb.pop_front();
    total_cnt++;
    if (to || cyc != W) $display("FAIL n1_lat got %0d want %0d", cyc, W);
    else pass_cnt++;
    total_cnt++;
    if (result !== e.res || err !== e.err)
      $display("FAIL n1_res got %h/%b want %h/%b", result, err, e.res, e.err);
    else pass_cnt++;
    total_cnt++;
    if (chk_fail !== 1'b0) $display("FAIL n1_chk got %b want 0", chk_fail);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL n1_after got b%b d%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_patterns();
    logic [NW-1:0] nv[3];
    logic [W-1:0]  ev[3];
    int cyc;
    bit to;
    exp_t e;
    nv[0] = NW'(3);
    ev[0] = 32'h5555_5555;
    nv[1] = rand_wide();
    nv[1][31:0] = 32'h3;
    ev[1] = 32'h5555_5555;
    nv[2] = rand_wide();
    nv[2][31:0] = 32'hFFFF_FFFF;
    ev[2] = 32'h0000_0001;
    for (int k = 0; k < 3; k++) begin
      issue(nv[k], ev[k], 1'b0);
      wait_done(cyc, to);
      e = sb.pop_front();
      total_cnt++;
      if (to || result !== e.res || err !== e.err || chk_fail !== 1'b0)
        $display("FAIL pat%0d got %h/%b/%b to%b want %h/%b/0",
                 k, result, err, chk_fail, to, e.res, e.err);
      else pass_cnt++;
    end
  endtask

  task automatic test_even();
    int cyc;
    bit to;
    exp_t e;
    issue(NW'(32'h10), '0, 1'b1);
    wait_done(cyc, to);
    e = sb.pop_front();
    total_cnt++;
    if (to || cyc != 1) $display("FAIL even_lat got %0d want 1", cyc);
    else pass_cnt++;
    total_cnt++;
    if (result !== e.res || err !== e.err)
      $display("FAIL even_res got %h/%b want %h/%b", result, err, e.res, e.err);
    else pass_cnt++;
    total_cnt++;
    if (chk_fail !== 1'b0) $display("FAIL even_chk got %b want 0", chk_fail);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || err !== 1'b1)
      $display("FAIL even_after got b%b e%b want b0 e1", busy, err);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] nl;
    logic [W-1:0] p;
    logic [NW-1:0] nv;
    int cyc;
    bit to;
    exp_t e;
    for (int k = 0; k < 1000; k++) begin
      nl = $urandom() | 32'h1;
      nv = rand_wide();
      nv[31:0] = nl;
      issue(nv, model_n0(nl), 1'b0);
      wait_done(cyc, to);
      e = sb.pop_front();
      total_cnt++;
      if (to || cyc != W || result !== e.res || err !== 1'b0 || chk_fail !== 1'b0)
        $display("FAIL rnd%0d n=%h got %h/%b/%b lat%0d want %h/0/0 lat%0d",
                 k, nl, result, err, chk_fail, cyc, e.res, W);
      else pass_cnt++;
      p = nl * result;
      total_cnt++;
      if (p !== '1) $display("FAIL rnd_prod%0d got %h want ffffffff", k, p);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    exp_t e;
    issue(NW'(3), 32'h5555_5555, 1'b0);
    cyc = 0;
    while (done !== 1'b1 && cyc <= TMO) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        n = NW'(1);
        start = 1'b1;
      end
      if (cyc == 11) start = 1'b0;
    end
    e = sb.pop_front();
    total_cnt++;
    if (cyc != W) $display("FAIL ign_lat got %0d want %0d", cyc, W);
    else pass_cnt++;
    total_cnt++;
    if (result !== e.res) $display("FAIL ign_res got %h want %h", result, e.res);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || result !== e.res)
      $display("FAIL ign_after got b%b r%h want b0 r%h", busy, result, e.res);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    bit seen;
    exp_t e;
    issue(NW'(1), 32'hFFFF_FFFF, 1'b0);
    void'(sb.pop_front());
    for (int k = 0; k < 15; k++) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL rst_pre busy got %b want 1", busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, err, chk_fail, result} !== '0)
      $display("FAIL rst_mid got b%b d%b e%b c%b r%h want 0",
               busy, done, err, chk_fail, result);
    else pass_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL rst_nodone got done=1 want none");
    else pass_cnt++;
    issue(NW'(32'hFFFF_FFFF), 32'h1, 1'b0);
    wait_done(cyc, to);
    e = sb.pop_front();
    total_cnt++;
    if (to || cyc != W || result !== e.res || err !== e.err)
      $display("FAIL rst_after got %h/%b lat%0d want %h/%b lat%0d",
               result, err, cyc, e.res, e.err, W);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int gap;
    bit to;
    exp_t e;
    e.res = 32'hFFFF_FFFF;
    e.err = 1'b0;
    sb.push_back(e);
    e.res = 32'h5555_5555;
    sb.push_back(e);
    @(negedge clk);
    n = NW'(1);
    start = 1'b1;
    @(negedge clk);
    n = NW'(3);
    wait_done(cyc, to);
    e = sb.pop_front();
    total_cnt++;
    if (to || result !== e.res)
      $display("FAIL b2b_first got %h want %h", result, e.res);
    else pass_cnt++;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) start = 1'b0;
    end while (done !== 1'b1 && gap <= TMO);
    e = sb.pop_front();
    total_cnt++;
    if (gap != W + 1) $display("FAIL b2b_gap got %0d want %0d", gap, W + 1);
    else pass_cnt++;
    total_cnt++;
    if (result !== e.res) $display("FAIL b2b_second got %h want %h", result, e.res);
    else pass_cnt++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_w16();
    int cyc;
    exp_t e;
    e.res = 32'h3333;
    e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    n2 = NW2'(5);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n2 = '1;
    cyc = 0;
    while (done2 !== 1'b1 && cyc <= TMO) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    total_cnt++;
    if (cyc != W2) $display("FAIL w16_lat got %0d want %0d", cyc, W2);
    else pass_cnt++;
    total_cnt++;
    if ({16'h0, result2} !== e.res || err2 !== e.err || chk2 !== 1'b0)
      $display("FAIL w16_res got %h/%b/%b want %h/%b/0",
               result2, err2, chk2, e.res, e.err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_n1();
    test_patterns();
    test_even();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_w16();
    test_random();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_left got %0d want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/n0prime_hensel.md
# n0prime_hensel

Computes the Montgomery constant n0' = −n⁻¹ mod 2^W from the low word of an odd modulus n, using bit-serial Hensel lifting with add/shift only. It replaces the divider-based extended-Euclid block. Word width and modulus width are parameters, and an even modulus is flagged as an error. It sits beside the modular-exponentiation datapath and is run once per key load, before any Montgomery multiply.

## Interface
- `NW`, 1024, modulus width in bits; only `n[W-1:0]` is consumed.
- `W`, 32, Montgomery word width; legal range 2 ≤ W ≤ NW.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only while `busy`=0.
- `n` in NW: modulus; sampled on the accepting edge only.
- `busy` out 1: high from the accepting edge until the edge that raises `done`.
- `done` out 1: one-cycle pulse when `result` and `err` are valid.
- `err` out 1: n was even; held until the next accepted start.
- `result` out W: n0'; held until the next completion.
- `chk_fail` out 1: self-check mismatch (see Configuration); held like `err`.

## Operation
- States: IDLE, CALC, FIN.
- Internal registers:
  - `nw` (W bits): captured low word of n.
  - `t` (W bits): running product n·y mod 2^W.
  - `y` (W bits): partial inverse.
  - `i` (index, $clog2(W) bits).
- IDLE, `start`=1:
  - Set `nw`←n[W-1:0], `t`←n[W-1:0], `y`←1, `i`←1, `busy`←1.
  - Clear `err` and `chk_fail`.
  - If n[0]=0: set `err`←1 and go to FIN. Otherwise go to CALC.
- CALC, one bit per cycle:
  - If t[i]=1, then `y[i]`←1 and `t`←t + (nw<<i), truncated to W bits.
  - Invariant after step i: t[i:0] = 1 followed by zeros.
  - `i`←i+1. Go to FIN after the step with i = W−1.
- FIN:
  - If `err`=0: `result` ← (~y + 1) mod 2^W. If `err`=1: `result` ← 0.
  - `done`←1 for one cycle, `busy`←0, return to IDLE.
- Width rule: all arithmetic is modulo 2^W. Upper bits of n are never read.
- `start` while `busy`=1 is ignored, with no queueing. `n` may change freely after acceptance.
- `start` held high across the `done` cycle is accepted again on the first IDLE edge, which is the edge after `done`.
- Asynchronous reset mid-operation aborts the computation. No `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `chk_fail`=0, `result`=0, state=IDLE.
- Odd n: start accepted at edge E0. CALC occupies E1..E(W−1). FIN registers outputs at E(W). Latency from acceptance to `done` is W cycles; for W=32 that is 32 cycles.
- Even n: `done` and `err` are set at E1, giving a latency of 1 cycle.
- Minimum start-to-start throughput is W+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `N0PRIME_SELFCHECK_EN` defined:
  - FIN also computes (nw · result) mod 2^W and compares it with all-ones.
  - On a mismatch with `err`=0, `chk_fail`←1.
  - The multiply is W×W truncated and combinational in FIN; latency is unchanged.
- Undefined: `chk_fail` is tied to 0 and no multiplier is instantiated.

## Structure
- Package `n0prime_pkg` holds:
  - the state enum (IDLE, CALC, FIN);
  - `N0_W_DEFAULT`=32 and `N0_NW_DEFAULT`=1024.
- Sub-module `n0inv_step` is the combinational Hensel step:
  - inputs: t, y, nw, i;
  - outputs: t_next, y_next.
  - It is instantiated once. A future radix-2^k version chains k copies.

## Test plan
- W=32, n=1 → `done` at cycle 32 after acceptance, `result`=0xFFFFFFFF, `err`=0.
- W=32, n=3 → `result`=0x55555555. Same `result` when n[1023:32] is random and n[31:0]=3.
- W=32, n[31:0]=0xFFFFFFFF → `result`=0x00000001. Also 1000 random odd n, each checked by the bench for n·result ≡ −1 mod 2^32.
- W=32, n=0x10 → `done` and `err`=1 one cycle after acceptance, `result`=0, `busy` low afterwards.
- Second `start` pulsed at cycle 10 of a run is ignored, and the first result is unchanged. `rst_n` asserted at cycle 15 → all outputs 0 and no `done`. A new start after release completes normally.
- W=16, NW=64, n=0x0000000000000005 → `result`=0x3333.
  - Check: 5·0xCCCD = 1 mod 2^16, and −0xCCCD = 0x3333.
- With `N0PRIME_SELFCHECK_EN` defined, `chk_fail`=0 on all the cases above.
